// File: rtl/term_gather_pkg.sv
// Shared types and helpers for the term_gather block: FSM state encoding and
// the width of the slot-occupancy counter.
package term_gather_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } gather_state_e;

    // Counter must represent 0..num_elements inclusive.
    function automatic int count_width(input int num_elements);
        return $clog2(num_elements + 1);
    endfunction

endpackage

// File: rtl/term_gather_ctrl.sv
// Control path for term_gather: FILL/HOLD handshake FSM plus the slot
// counter that addresses the next free slot.
module term_gather_ctrl
    import term_gather_pkg::*;
#(
    parameter  int NUM_ELEMENTS = 9,
    localparam int CNT_W        = count_width(NUM_ELEMENTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic             accept,
    output logic             drain,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_ELEMENTS - 1);

    gather_state_e    state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: every output and next-state signal gets a default before the case,
    // so no path through this block can leave a value unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        in_ready  = (state_q == FILL);
        out_valid = (state_q == HOLD);
        accept    = in_valid && in_ready;
        drain     = out_valid && out_ready;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    count_d = count_q + CNT_W'(1);
                    // A last flag on the final slot is still a single HOLD entry.
                    if ((count_q == LAST_SLOT) || in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (drain) begin
                    count_d = '0;
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
                count_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/term_gather.sv
// Collects up to NUM_ELEMENTS terms into a zero-padded vector for a downstream
// adder. Optional running sum output enabled by TERM_GATHER_RUNSUM_EN.
module term_gather
    import term_gather_pkg::*;
#(
    parameter  int NUM_ELEMENTS = 9,
    parameter  int BIT_LEN      = 16,
    localparam int CNT_W        = count_width(NUM_ELEMENTS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BIT_LEN-1:0] in_term,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BIT_LEN-1:0] out_terms [NUM_ELEMENTS],
    output logic [CNT_W-1:0]   out_count
`ifdef TERM_GATHER_RUNSUM_EN
    ,
    output logic [BIT_LEN-1:0] out_sum
`endif
);

    logic             accept;
    logic             drain;
    logic [CNT_W-1:0] count;

    logic [BIT_LEN-1:0] slots_q [NUM_ELEMENTS];
    logic [BIT_LEN-1:0] slots_d [NUM_ELEMENTS];

    term_gather_ctrl #(
        .NUM_ELEMENTS (NUM_ELEMENTS)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .accept    (accept),
        .drain     (drain),
        .count     (count)
    );

    // Unwritten slots must read zero so the downstream sum is exact.
    always_comb begin
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            if (drain) begin
                slots_d[i] = '0;
            end else if (accept && (count == CNT_W'(i))) begin
                slots_d[i] = in_term;
            end else begin
                slots_d[i] = slots_q[i];
            end
        end
    end

    // NOTE: the slot array is reset on purpose: a reset must discard any
    // partial group and present all-zero terms, so this storage cannot be a
    // reset-less RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            slots_q <= slots_d;
        end
    end

    assign out_terms = slots_q;
    assign out_count = count;

`ifdef TERM_GATHER_RUNSUM_EN
    logic [BIT_LEN-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (drain) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + in_term;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign out_sum = sum_q;
`endif

    // A held vector must not change until the consumer takes it.
    assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_count)));

endmodule

// File: tb/tb_term_gather.sv
// Directed self-checking bench for term_gather (default 9 x 16-bit build).
// Running-sum checks compile in only when TERM_GATHER_RUNSUM_EN is defined.
module tb_term_gather;

    localparam int N  = 9;
    localparam int BW = 16;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_term;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_terms [N];
    logic [CW-1:0] out_count;
`ifdef TERM_GATHER_RUNSUM_EN
    logic [BW-1:0] out_sum;
`endif

    int checks = 0;
    int errors = 0;

    term_gather #(
        .NUM_ELEMENTS (N),
        .BIT_LEN      (BW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_term   (in_term),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_terms (out_terms),
        .out_count (out_count)
`ifdef TERM_GATHER_RUNSUM_EN
        ,
        .out_sum   (out_sum)
`endif
    );

    always #5 clk = ~clk;

    // Drive one term (after idle gap cycles with junk on the bus), wait for
    // acceptance, and return at the negedge following the accepting edge.
    task automatic push(input logic [BW-1:0] v, input logic last, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_term  = 16'hBEEF;
            in_last  = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_term  = v;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: in_ready stayed %0b, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_term  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [BW-1:0] zero;
        zero = '0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%0b out_valid=%0b, required 1 0", in_ready, out_valid);
        end
        checks++;
        if (out_count !== '0) begin
            errors++;
            $display("FAIL reset_count: got %0d, required 0", out_count);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (out_terms[i] !== zero) begin
                errors++;
                $display("FAIL reset_slot%0d: got %h, required %h", i, out_terms[i], zero);
            end
        end
    endtask

    task automatic test_full_group();
        for (int i = 1; i <= N; i++) push(BW'(i), 1'b0, 0);
        // Inputs during HOLD must be ignored.
        in_valid = 1'b1;
        in_term  = 16'hDEAD;
        in_last  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL full_hs c%0d: in_ready=%0b out_valid=%0b, required 0 1", c, in_ready, out_valid);
            end
            checks++;
            if (out_count !== CW'(9)) begin
                errors++;
                $display("FAIL full_count c%0d: got %0d, required 9", c, out_count);
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (out_terms[i] !== BW'(i + 1)) begin
                    errors++;
                    $display("FAIL full_slot%0d c%0d: got %0d, required %0d", i, c, out_terms[i], i + 1);
                end
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== '0) begin
            errors++;
            $display("FAIL full_drain: in_ready=%0b out_valid=%0b count=%0d, required 1 0 0",
                     in_ready, out_valid, out_count);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (out_terms[i] !== '0) begin
                errors++;
                $display("FAIL drain_slot%0d: got %0d, required 0", i, out_terms[i]);
            end
        end
    endtask

    task automatic test_short_group();
        logic [BW-1:0] exp_t [N];
        push(16'd5, 1'b0, 0);
        push(16'd6, 1'b0, 1);
        push(16'd7, 1'b1, 0);
        for (int i = 0; i < N; i++) exp_t[i] = '0;
        exp_t[0] = 16'd5;
        exp_t[1] = 16'd6;
        exp_t[2] = 16'd7;
        checks++;
        if (out_valid !== 1'b1 || out_count !== CW'(3)) begin
            errors++;
            $display("FAIL short_hdr: out_valid=%0b count=%0d, required 1 3", out_valid, out_count);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (out_terms[i] !== exp_t[i]) begin
                errors++;
                $display("FAIL short_slot%0d: got %0d, required %0d", i, out_terms[i], exp_t[i]);
            end
        end
`ifdef TERM_GATHER_RUNSUM_EN
        checks++;
        if (out_sum !== 16'd18) begin
            errors++;
            $display("FAIL short_sum: got %0d, required 18", out_sum);
        end
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int hold_cycles;
        logic [BW-1:0] exp_t [N];
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(BW'(11 + i), i == 3, 0);
        hold_cycles = 0;
        checks++;
        if (out_valid !== 1'b1 || out_count !== CW'(4)) begin
            errors++;
            $display("FAIL b2b_g1: out_valid=%0b count=%0d, required 1 4", out_valid, out_count);
        end
        if (out_valid) hold_cycles++;
        // Second group driven immediately; first accept lands after the single HOLD cycle.
        push(16'd7, 1'b0, 0);
        checks++;
        if (out_valid !== 1'b0 || out_count !== CW'(1)) begin
            errors++;
            $display("FAIL b2b_one_hold: out_valid=%0b count=%0d, required 0 1", out_valid, out_count);
        end
        push(16'd8, 1'b1, 0);
        out_ready = 1'b0;
        checks++;
        if (hold_cycles !== 1) begin
            errors++;
            $display("FAIL b2b_hold_cycles: got %0d, required 1", hold_cycles);
        end
        for (int i = 0; i < N; i++) exp_t[i] = '0;
        exp_t[0] = 16'd7;
        exp_t[1] = 16'd8;
        checks++;
        if (out_valid !== 1'b1 || out_count !== CW'(2)) begin
            errors++;
            $display("FAIL b2b_g2: out_valid=%0b count=%0d, required 1 2", out_valid, out_count);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (out_terms[i] !== exp_t[i]) begin
                errors++;
                $display("FAIL b2b_slot%0d: got %0d, required %0d", i, out_terms[i], exp_t[i]);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        push(16'hFFFF, 1'b0, 0);
        push(16'h0002, 1'b1, 0);
        checks++;
        if (out_count !== CW'(2) || out_terms[0] !== 16'hFFFF || out_terms[1] !== 16'h0002) begin
            errors++;
            $display("FAIL wrap_terms: count=%0d t0=%h t1=%h, required 2 ffff 0002",
                     out_count, out_terms[0], out_terms[1]);
        end
`ifdef TERM_GATHER_RUNSUM_EN
        checks++;
        if (out_sum !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_sum: got %h, required 0001", out_sum);
        end
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid(input int scenario);
        if (scenario == 0) begin
            push(16'd21, 1'b0, 0);
            push(16'd22, 1'b1, 0);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL rst_hold_pre: out_valid=%0b, required 1", out_valid);
            end
        end else begin
            for (int i = 0; i < 4; i++) push(BW'(31 + i), 1'b0, 0);
        end
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== '0) begin
            errors++;
            $display("FAIL rst_mid%0d: out_valid=%0b in_ready=%0b count=%0d, required 0 1 0",
                     scenario, out_valid, in_ready, out_count);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (out_terms[i] !== '0) begin
                errors++;
                $display("FAIL rst_mid%0d_slot%0d: got %0d, required 0", scenario, i, out_terms[i]);
            end
        end
`ifdef TERM_GATHER_RUNSUM_EN
        checks++;
        if (out_sum !== '0) begin
            errors++;
            $display("FAIL rst_mid%0d_sum: got %0d, required 0", scenario, out_sum);
        end
`endif
    endtask

    task automatic test_random_valid();
        int gaps [N] = '{2, 0, 3, 1, 0, 4, 1, 2, 3};
        for (int i = 0; i < N; i++) begin
            push(BW'(100 + i), i == N - 1, gaps[i]);
            checks++;
            if (out_valid !== (i == N - 1)) begin
                errors++;
                $display("FAIL rand_valid%0d: out_valid=%0b, required %0b", i, out_valid, i == N - 1);
            end
        end
        checks++;
        if (out_count !== CW'(9) || out_terms[8] !== 16'd108 || out_terms[0] !== 16'd100) begin
            errors++;
            $display("FAIL rand_group: count=%0d t0=%0d t8=%0d, required 9 100 108",
                     out_count, out_terms[0], out_terms[8]);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rand_no_dup c%0d: out_valid=%0b in_ready=%0b, required 0 1",
                         c, out_valid, in_ready);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_term   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        test_reset();
        test_full_group();
        test_short_group();
        test_back_to_back();
        test_wrap();
        test_reset_mid(0);
        test_reset_mid(1);
        test_random_valid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
